// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: one req/gnt/rvalid transaction per memory op,
// with store lane replication, load extraction/extension and a wait timeout.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ex_valid_i,
    input  logic        ex_load_i,
    input  logic        ex_store_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    output logic        lsu_busy_o,
    output logic        lsu_done_o,
    output logic [31:0] mem_dat_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        accept, unsupported, misaligned, start_bus, timeout;
    logic        err_d, err_q, mis_d, mis_q;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] addr_q, wdata_q, ld_data, mem_dat_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [15:0] wait_cnt_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Accept is gated by reset so every output, busy included, reads 0 during reset.
    // NOTE: each always_comb assigns every output first, so no path can infer a latch.
    always_comb begin
        accept      = rst_n_i && (state_q == IDLE) && ex_valid_i && (ex_load_i || ex_store_i);
        unsupported = ex_load_i ? (ex_funct3_i inside {3'd3, 3'd6, 3'd7})
                                : (ex_funct3_i >= 3'd3);
        misaligned  = !unsupported &&
                      (((ex_funct3_i[1:0] == 2'd1) && ex_addr_i[0]) ||
                       ((ex_funct3_i[1:0] == 2'd2) && (ex_addr_i[1:0] != 2'b00)));
        start_bus   = accept && !unsupported && !misaligned;
    end

    always_comb begin
        st_be    = 4'hF;
        st_wdata = ex_wdata_i;
        case (ex_funct3_i[1:0])
            2'd0: begin
                st_be    = 4'b0001 << ex_addr_i[1:0];
                st_wdata = {4{ex_wdata_i[7:0]}};
            end
            2'd1: begin
                st_be    = 4'b0011 << ex_addr_i[1:0];
                st_wdata = {2{ex_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (funct3_q)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {24'd0, ld_byte};
            3'd5:    ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    assign timeout = (wait_cnt_q == WAIT_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (unsupported) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (misaligned) begin
                        state_d = DONE;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_d = we_q ? DONE : RESP;
                end else if (timeout) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                if (dmem_rvalid_i) begin
                    state_d = DONE;
                end else if (timeout) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured once at accept and stay frozen until the next op.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            mis_q      <= 1'b0;
            mem_dat_q  <= '0;
        end else begin
            if (start_bus) begin
                addr_q   <= ex_addr_i;
                funct3_q <= ex_funct3_i;
                we_q     <= !ex_load_i;
                be_q     <= ex_load_i ? 4'h0 : st_be;
                wdata_q  <= ex_load_i ? 32'd0 : st_wdata;
            end
            if (state_d != state_q)
                wait_cnt_q <= '0;
            else if ((state_q == REQ) || (state_q == RESP))
                wait_cnt_q <= wait_cnt_q + 16'd1;
            err_q <= err_d;
            mis_q <= mis_d;
            if ((state_q == RESP) && dmem_rvalid_i)
                mem_dat_q <= ld_data;
        end
    end

    always_comb begin
        lsu_busy_o = accept || (state_q == REQ) || (state_q == RESP);
        dmem_req_o = (state_q == REQ);
        lsu_done_o = (state_q == DONE);
        bus_err_o  = (state_q == DONE) && err_q;
        misalign_o = (state_q == DONE) && mis_q;
    end

    assign mem_dat_o    = mem_dat_q;
    assign dmem_we_o    = we_q;
    assign dmem_be_o    = be_q;
    assign dmem_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem_wdata_o = wdata_q;

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store unit for the MEM stage of the RISC-V core. Takes the address and store data produced by EX and runs one request/grant/response transaction on the data-memory bus. Formats load data by size and sign and drives it to the writeback-select mux memory input. While a transaction is in flight it stalls the pipeline.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for gnt or rvalid before abort with bus error (1..65535)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
ex_valid_i  in  1  EX presents a memory op this cycle
ex_load_i  in  1  op is a load
ex_store_i  in  1  op is a store
ex_funct3_i  in  3  RV32I funct3: size and sign
ex_addr_i  in  32  byte address (ALU result)
ex_wdata_i  in  32  store data (rs2)
lsu_busy_o  out  1  stall request to pipeline
lsu_done_o  out  1  one-cycle pulse: op finished (ok or error)
mem_dat_o  out  32  formatted load data to writeback mux
misalign_o  out  1  one-cycle pulse: misaligned access
bus_err_o  out  1  one-cycle pulse: timeout or unsupported funct3
dmem_req_o  out  1  bus request
dmem_we_o  out  1  1 = write
dmem_be_o  out  4  byte enables
dmem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
dmem_wdata_o  out  32  lane-replicated store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  32  read data

Behaviour:
- Reset (async, rst_n_i=0):
  - state IDLE, timeout counter 0.
  - All outputs 0, including mem_dat_o.
  - Any in-flight request is dropped immediately and not replayed.
- States: IDLE, REQ, RESP, DONE.
- IDLE, accept when ex_valid_i & (ex_load_i | ex_store_i):
  - If both load and store are set, treat as load.
  - Load funct3 3, 6, 7 or store funct3 >= 3 is unsupported: pulse bus_err_o and lsu_done_o next cycle via DONE. No bus activity.
  - Misaligned access is halfword with addr[0]=1, or word with addr[1:0]!=0. Pulse misalign_o and lsu_done_o next cycle via DONE. No bus activity.
  - Otherwise latch addr, funct3, we, be and wdata, then go to REQ.
  - lsu_busy_o is asserted combinationally in the accept cycle so the pipeline holds EX.
- REQ:
  - dmem_req_o=1. Address, we, be and wdata are held stable until gnt.
  - Sampled dmem_gnt_i=1: store goes to DONE, load goes to RESP.
- RESP:
  - Wait for dmem_rvalid_i; its earliest cycle is the one after gnt. dmem_req_o=0.
  - On rvalid: register formatted data into mem_dat_o, go to DONE.
- DONE:
  - lsu_done_o=1 for exactly one cycle, lsu_busy_o=0, return to IDLE.
  - A new op cannot be accepted in DONE. The earliest next accept is the following cycle.
- lsu_busy_o = accept-in-IDLE | REQ | RESP.
- Timeout:
  - The counter clears on entering REQ or RESP and increments each waiting cycle.
  - When it reaches TIMEOUT_CYCLES without gnt or rvalid: drop req, go to DONE, pulse bus_err_o.
  - mem_dat_o is unchanged on timeout.
- Store formatting, lane = addr[1:0]:
  - SB: wdata={4{b}}, be=4'b0001<<lane.
  - SH: wdata={2{h}}, be=4'b0011<<lane.
  - SW: wdata as-is, be=4'hF.
- Load formatting:
  - LB / LBU select byte at lane, then sign-extend or zero-extend.
  - LH / LHU select halfword at addr[1], then sign-extend or zero-extend.
  - LW uses the full word.
- mem_dat_o holds its last value until the next successful load.
- Stray inputs are ignored: rvalid outside RESP, gnt outside REQ.
- Latency with zero-wait bus (gnt in first REQ cycle, rvalid next cycle): accept at cycle 0, done pulse at cycle 3 for a load, cycle 2 for a store.

Test Plan:
- LB at 0x1003, gnt immediate, rdata 0x80112233 -> dmem_addr 0x1000, be 4'h0, we 0; mem_dat_o 0xFFFFFF80; done at cycle 3.
- LHU at 0x2002, rdata 0xBEEF1234 -> mem_dat_o 0x0000BEEF.
- SB 0x000000A5 at 0x3001 -> dmem_wdata 0xA5A5A5A5, be 4'b0010, we 1; done at cycle 2; mem_dat_o unchanged.
- LW at 0x4002 -> misalign_o=1 and lsu_done_o=1 one cycle later; dmem_req_o never asserted.
- LW with gnt delayed 3 cycles, rvalid 2 cycles after gnt, rdata 0xDEADBEEF:
  - req is held stable for 4 cycles.
  - busy is asserted throughout.
  - mem_dat_o = 0xDEADBEEF.
- TIMEOUT_CYCLES=4, no gnt -> bus_err_o pulse after 4 REQ cycles, then req drops.
- rst_n_i low during RESP -> outputs go 0 immediately; a late rvalid after reset is ignored.
